// File: rtl/fec_encoder_arbiter_if.sv
// Bundle between message sources, the shared FEC encoder and result sinks.
// master = arbiter side, slave = sources/encoder side.
interface fec_encoder_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        src_ready;
  logic                      enc_req;
  logic [DATA_W-1:0]         enc_data_in;
  logic                      enc_ack;
  logic [DATA_W-1:0]         enc_data_out;
  logic [NUM_SRC-1:0]        dst_valid;
  logic [DATA_W-1:0]         dst_data;

  modport master (
    input  src_valid, src_data, enc_ack, enc_data_out,
    output src_ready, enc_req, enc_data_in, dst_valid, dst_data
  );

  modport slave (
    output src_valid, src_data, enc_ack, enc_data_out,
    input  src_ready, enc_req, enc_data_in, dst_valid, dst_data
  );
endinterface

// File: rtl/fec_encoder_arbiter.sv
// Round-robin sharing of one in-order FEC encoder among NUM_SRC sources.
// A tag FIFO records the issuer of each in-flight word for result routing.
module fec_encoder_arbiter #(
  parameter int NUM_SRC      = 4,
  parameter int DATA_W       = 8,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  fec_encoder_arbiter_if.master         bus,
  output logic                          enc_rst_n,
  output logic                          enc_en,
  output logic [$clog2(MAX_INFLIGHT):0] inflight_cnt,
  output logic                          orphan_err
);
  localparam int SW = $clog2(NUM_SRC);
  localparam int PW = $clog2(MAX_INFLIGHT);
  localparam int CW = PW + 1;

  logic [SW-1:0]      r_rr;
  logic [CW-1:0]      r_cnt;
  logic [PW-1:0]      r_wp;
  logic [PW-1:0]      r_rp;
  logic [SW-1:0]      r_tag [MAX_INFLIGHT];
  logic               r_req;
  logic [DATA_W-1:0]  r_din;
  logic               r_en;
  logic [NUM_SRC-1:0] r_dv;
  logic [DATA_W-1:0]  r_dd;
  logic               r_orphan;

  logic               w_elig;
  logic               w_found;
  logic [SW-1:0]      w_gidx;
  logic [NUM_SRC-1:0] w_grant;
  logic [DATA_W-1:0]  w_word;
  logic               w_pop;
  logic               w_empty;
  logic [NUM_SRC-1:0] w_tag_oh;

  assign w_empty = (r_cnt == '0);
  assign w_elig  = en & ~rst & (r_cnt < CW'(MAX_INFLIGHT));
  assign w_pop   = bus.enc_ack & ~w_empty;

  // Search starts one past the last winner so each source waits at most NUM_SRC-1 grants
  always_comb begin
    int j;
    j       = 0;
    w_found = 1'b0;
    w_gidx  = '0;
    w_grant = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      j = (int'(r_rr) + k) % NUM_SRC;
      if (w_elig && !w_found && bus.src_valid[j]) begin
        w_found = 1'b1;
        w_gidx  = SW'(j);
      end
    end
    if (w_found) w_grant[w_gidx] = 1'b1;
  end

  assign w_word   = bus.src_data[w_gidx*DATA_W +: DATA_W];
  assign w_tag_oh = NUM_SRC'(1) << r_tag[r_rp];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr     <= SW'(NUM_SRC - 1);
      r_cnt    <= '0;
      r_wp     <= '0;
      r_rp     <= '0;
      r_req    <= 1'b0;
      r_din    <= '0;
      r_en     <= 1'b0;
      r_dv     <= '0;
      r_dd     <= '0;
      r_orphan <= 1'b0;
    end else begin
      r_en  <= en;
      r_req <= w_found;
      r_dv  <= '0;
      if (w_found) begin
        r_din <= w_word;
        r_wp  <= r_wp + 1'b1;
        r_rr  <= w_gidx;
      end
      if (w_pop) begin
        r_dv <= w_tag_oh;
        r_dd <= bus.enc_data_out;
        r_rp <= r_rp + 1'b1;
      end
      if (bus.enc_ack && w_empty) r_orphan <= 1'b1;
      if (w_found && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_found && w_pop) r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_found) r_tag[r_wp] <= w_gidx;
  end

  assign bus.src_ready   = w_grant;
  assign bus.enc_req     = r_req;
  assign bus.enc_data_in = r_din;
  assign bus.dst_valid   = r_dv;
  assign bus.dst_data    = r_dd;
  assign enc_rst_n       = ~rst;
  assign enc_en          = r_en;
  assign inflight_cnt    = r_cnt;
  assign orphan_err      = r_orphan;
endmodule

// File: doc/fec_encoder_arbiter.md
Name: fec_encoder_arbiter

Overview:
- Shares one encoder_fec instance among NUM_SRC independent requesters using round-robin arbitration.
- Forwards the granted word to the encoder's req/data_in side.
- Tracks the source ID of every in-flight word in an ordered tag FIFO, and routes each encoder ack/data_out back to the source that issued the word.
- Sits between the message sources and encoder_fec; encoder results return in issue order with a fixed but unspecified latency.

Parameters:
- NUM_SRC, 4, number of requesters (2..8).
- DATA_W, 8, width of message_data_t.
- MAX_INFLIGHT, 8, tag FIFO depth and maximum number of outstanding words in the encoder (power of 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  arbitration enable; 0 blocks new grants while in-flight words still drain.
- src_valid  in  NUM_SRC  per-source word available.
- src_data  in  NUM_SRC*DATA_W  per-source word; slice i belongs to source i.
- src_ready  out  NUM_SRC  one-hot grant; a transfer occurs when src_valid[i] & src_ready[i].
- enc_rst_n  out  1  encoder reset, equal to ~rst (combinational).
- enc_en  out  1  encoder enable, registered copy of en.
- enc_req  out  1  word presented to the encoder.
- enc_data_in  out  DATA_W  word to the encoder.
- enc_ack  in  1  encoder result valid.
- enc_data_out  in  DATA_W  encoder result.
- dst_valid  out  NUM_SRC  one-hot result-valid pulse for the owning source.
- dst_data  out  DATA_W  result word, shared by all sources.
- inflight_cnt  out  $clog2(MAX_INFLIGHT)+1  number of outstanding words.
- orphan_err  out  1  sticky flag: enc_ack arrived while the tag FIFO was empty.

Behaviour:
- Reset (synchronous, sampled at the posedge while rst=1) forces the following:
  - src_ready=0, enc_req=0, enc_data_in=0, enc_en=0, dst_valid=0, dst_data=0.
  - inflight_cnt=0, orphan_err=0.
  - Tag FIFO pointers cleared; round-robin pointer rr=NUM_SRC-1.
- Reset mid-operation discards all in-flight tags. enc_rst_n is low for the same cycles, so the encoder pipeline is flushed too.
- Grant (combinational):
  - Eligible iff en=1, rst=0 and inflight_cnt < MAX_INFLIGHT.
  - When eligible, grant the first i with src_valid[i]=1, searching rr+1, rr+2, … modulo NUM_SRC.
  - src_ready is one-hot or zero; src_ready[i] never asserts unless src_valid[i]=1.
- Issue:
  - On a transfer at edge T: push tag i into the FIFO and set rr=i.
  - During cycle T+1: enc_req=1 and enc_data_in=src_data slice i. enc_req is a single-cycle pulse per transfer.
  - Back-to-back transfers give consecutive enc_req cycles.
  - enc_data_in holds its last value when enc_req=0.
- Return:
  - On an edge with enc_ack=1 and the FIFO non-empty: pop tag t.
  - During the next cycle: dst_valid = one-hot(t) and dst_data = enc_data_out sampled at that edge.
  - dst_valid deasserts the following cycle unless another ack was sampled.
  - Sources must accept dst_valid unconditionally; there is no backpressure.
- Orphan ack: enc_ack=1 with the FIFO empty sets orphan_err (held until rst). No pop and no dst_valid are generated.
- Counting:
  - inflight_cnt +1 on transfer, -1 on a valid pop; unchanged when both occur on the same edge.
  - When full (cnt=MAX_INFLIGHT), there is no grant even if an ack arrives that cycle; there is no bypass.
- Wrap-around: FIFO read/write pointers wrap modulo MAX_INFLIGHT; the rr pointer wraps modulo NUM_SRC.
- en=0: grants stop on the same cycle. Pending acks still pop and route normally; enc_en follows en one cycle later.
- Fairness: with all sources valid continuously, grants follow 0,1,2,3,0,… Each source waits at most NUM_SRC-1 transfers.

Test Plan:
- Reset check: rst=1 for 3 cycles with all src_valid=1 → src_ready=0, enc_req=0, inflight_cnt=0, enc_rst_n=0 throughout.
- Single source: only src_valid[2]=1 with data 8'hA5, encoder loopback latency 3 → enc_req pulse carrying 8'hA5 the cycle after the grant; 3 cycles later dst_valid=4'b0100 and dst_data=8'hA5.
- Round robin: all 4 sources valid for 8 cycles → grant order 0,1,2,3,0,1,2,3. Every result is routed to its issuer; a scoreboard per source matches data in order.
- Full stall: encoder ack held off for 20 cycles with sources valid → exactly 8 transfers, inflight_cnt=8, src_ready=0. After the first ack, one new grant follows on the next cycle.
- Simultaneous events: transfer and ack on the same edge with cnt=5 → cnt stays 5 and both tags are handled correctly. Injecting enc_ack with cnt=0 → orphan_err=1 and no dst_valid.
- en and reset mid-flight: en=0 with 4 words outstanding → no grants, all 4 results delivered. Asserting rst with 3 outstanding → cnt=0, orphan_err=0, and no dst_valid for the flushed words.
